axis_arb_mux: RTL and testbench
===============================

# axis_arb_mux

Packet-aware N-to-1 AXI-Stream multiplexer: the merge counterpart of the broadcaster. It collects NUM_STREAMS input streams onto one output stream using round-robin arbitration at packet granularity. A grant is held from the first beat through the tlast beat, so packets are never interleaved. The output is registered and sits in front of any single-stream consumer (MAC TX, FIFO, serialiser) fed by several producers.

## Interface
- AXIS_BYTES, 1, tdata width in bytes (tdata is AXIS_BYTES*8 bits)
- AXIS_USER_BITS, 1, tuser width per stream
- NUM_STREAMS, 2, number of input streams (≥2)
- ID_BITS, $clog2(NUM_STREAMS), width of the source-index output

Ports:
- clk  input  1  sole clock; all logic rising-edge
- areset  input  1  asynchronous, active-high reset
- axis_i_tready  output  NUM_STREAMS  per-stream ready
- axis_i_tvalid  input  NUM_STREAMS  per-stream valid
- axis_i_tlast  input  NUM_STREAMS  per-stream last
- axis_i_tdata  input  NUM_STREAMS*AXIS_BYTES*8  stream i in slice [(i+1)*AXIS_BYTES*8-1 -: AXIS_BYTES*8]
- axis_i_tuser  input  NUM_STREAMS*AXIS_USER_BITS  stream i in slice [(i+1)*AXIS_USER_BITS-1 -: AXIS_USER_BITS]
- axis_o_tready  input  1  output ready
- axis_o_tvalid  output  1  output valid (registered)
- axis_o_tlast  output  1  output last (registered)
- axis_o_tdata  output  AXIS_BYTES*8  output data (registered)
- axis_o_tuser  output  AXIS_USER_BITS  output user (registered)
- axis_o_tid  output  ID_BITS  index of the source stream of the current beat (registered)

## Operation
- States: IDLE (no grant) and LOCKED (grant = G).
- IDLE: if any axis_i_tvalid is set, choose the first valid stream searching from (last_grant+1) mod NUM_STREAMS upward, with wrap-around. On the next edge, set G to that stream, set last_grant to G, and enter LOCKED. If no stream is valid, stay in IDLE.
- LOCKED: axis_i_tready[G] = (!axis_o_tvalid || axis_o_tready). All other ready bits are 0. In IDLE, all ready bits are 0.
- A beat is accepted when axis_i_tvalid[G] && axis_i_tready[G]. On that edge the output register loads tdata/tuser/tlast slices of G, loads axis_o_tid = G, and sets axis_o_tvalid = 1.
- The output register clears axis_o_tvalid on an edge where axis_o_tready = 1 and no new beat is accepted.
- An accepted beat with tlast = 1 returns the block to IDLE on that edge.
- Requests from non-granted streams are ignored until the current packet ends. An input deasserting tvalid mid-packet only stalls the output; the grant is held.
- Validity of a request is only sampled in IDLE. A stream that raises tvalid while another stream holds the grant competes at the next arbitration.
- No data is transformed, dropped, or duplicated. The beat order within a packet is preserved.

## Timing
- Reset (async assert): axis_o_tvalid=0, axis_o_tlast=0, axis_o_tdata=0, axis_o_tuser=0, axis_o_tid=0, axis_i_tready=0, state IDLE, last_grant=NUM_STREAMS-1 (stream 0 wins first).
- Reset mid-packet: the partial packet is discarded. Outputs take reset values immediately, with no recovery beat.
- Arbitration costs one bubble cycle per packet. A request seen in IDLE at cycle n is granted at edge n+1. The first beat can be accepted in cycle n+1 and appears on the output in cycle n+2.
- Within a packet, throughput is 1 beat/cycle when the source and sink are continuously ready. Latency is 1 cycle, input to output.
- axis_i_tready depends combinationally on axis_o_tready and state. There is no combinational path from any tvalid to any tready.
- Backpressure: when axis_o_tvalid=1 and axis_o_tready=0, the output holds stable and axis_i_tready[G]=0.
- Single-beat packets (tlast on the first beat) run IDLE→LOCKED→IDLE, taking 2 cycles per packet at best.

## Test plan
- Streams 0 and 1 both present a 4-beat packet (data 0x10..0x13 and 0x20..0x23) from reset. The output must show 0x10..0x13 with tid=0, tlast only on 0x13, then 0x20..0x23 with tid=1. No interleaving; exactly one bubble between the packets.
- Stream 1 only, 3-beat packet, sink always ready, request at cycle 0. First output tvalid in cycle 2, beats back-to-back, axis_i_tready[0] stays 0 throughout.
- Round-robin fairness with NUM_STREAMS=3 and all streams continuously sending 1-beat packets. The tid sequence must be 0,1,2,0,1,2…
- Random sink backpressure (axis_o_tready toggling) on a 6-beat packet. The output holds stable while stalled; all 6 beats are delivered once and in order; the source tready mirrors the sink.
- Source gap: stream 0 drops tvalid for 3 cycles mid-packet while stream 1 requests. The grant stays on 0 until its tlast, then moves to 1.
- areset asserted mid-packet (beat 2 of 5). All outputs go to reset values at once. After release, a new packet from stream 0 is delivered intact with tid=0.

Source files
------------

// File: rtl/axis_arb_mux.sv
// Packet-aware N-to-1 AXI-Stream merge with round-robin arbitration.
// Arbitration happens only between packets. The grant is held from the
// first beat through the tlast beat, and the output stage is a single
// registered beat.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | no grant; choose the next valid stream after last_grant
// ST_LOCKED | grant_q owns the output until its tlast beat is accepted
module axis_arb_mux #(
    parameter int AXIS_BYTES     = 1,
    parameter int AXIS_USER_BITS = 1,
    parameter int NUM_STREAMS    = 2,
    parameter int ID_BITS        = $clog2(NUM_STREAMS)
) (
    input  logic                                  clk,
    input  logic                                  areset,
    output logic [NUM_STREAMS-1:0]                axis_i_tready,
    input  logic [NUM_STREAMS-1:0]                axis_i_tvalid,
    input  logic [NUM_STREAMS-1:0]                axis_i_tlast,
    input  logic [NUM_STREAMS*AXIS_BYTES*8-1:0]   axis_i_tdata,
    input  logic [NUM_STREAMS*AXIS_USER_BITS-1:0] axis_i_tuser,
    input  logic                                  axis_o_tready,
    output logic                                  axis_o_tvalid,
    output logic                                  axis_o_tlast,
    output logic [AXIS_BYTES*8-1:0]               axis_o_tdata,
    output logic [AXIS_USER_BITS-1:0]             axis_o_tuser,
    output logic [ID_BITS-1:0]                    axis_o_tid
);

    localparam int DW = AXIS_BYTES * 8;
    localparam int UW = AXIS_USER_BITS;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ID_BITS-1:0]  grant_q, grant_d;
    logic [ID_BITS-1:0]  last_grant_q, last_grant_d;
    logic                o_valid_q, o_valid_d;
    logic                o_last_q, o_last_d;
    logic [DW-1:0]       o_data_q, o_data_d;
    logic [UW-1:0]       o_user_q, o_user_d;
    logic [ID_BITS-1:0]  o_id_q, o_id_d;

    logic                pick_valid;
    logic [ID_BITS-1:0]  pick_idx;
    logic [ID_BITS-1:0]  cand;
    logic [NUM_STREAMS-1:0] ready_vec;
    logic                accept;
    logic                g_last;
    logic [DW-1:0]       g_data;
    logic [UW-1:0]       g_user;

    // (base + off) mod NUM_STREAMS, with off in 1..NUM_STREAMS
    function automatic logic [ID_BITS-1:0] wrap_idx(input logic [ID_BITS-1:0] base,
                                                    input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_STREAMS) s = s - NUM_STREAMS;
        return ID_BITS'(s);
    endfunction

    // Round-robin search: first valid stream after last_grant, wrapping
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= NUM_STREAMS; i++) begin
            cand = wrap_idx(last_grant_q, i);
            if (!pick_valid && axis_i_tvalid[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Only the granted stream sees ready; it depends on state and the sink alone
    always_comb begin
        ready_vec = '0;
        if (state_q == ST_LOCKED) begin
            ready_vec[grant_q] = !o_valid_q || axis_o_tready;
        end
    end

    assign axis_i_tready = ready_vec;
    assign accept = (state_q == ST_LOCKED) && axis_i_tvalid[grant_q] && ready_vec[grant_q];
    assign g_last = axis_i_tlast[grant_q];
    assign g_data = axis_i_tdata[int'(grant_q)*DW +: DW];
    assign g_user = axis_i_tuser[int'(grant_q)*UW +: UW];

    // Next-state, grant bookkeeping and output-register load/drain
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        o_valid_d    = o_valid_q;
        o_last_d     = o_last_q;
        o_data_d     = o_data_q;
        o_user_d     = o_user_q;
        o_id_d       = o_id_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d      = pick_idx;
                    last_grant_d = pick_idx;
                    state_d      = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (accept && g_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            o_valid_d = 1'b1;
            o_last_d  = g_last;
            o_data_d  = g_data;
            o_user_d  = g_user;
            o_id_d    = grant_q;
        end else if (axis_o_tready) begin
            o_valid_d = 1'b0;
        end
    end

    // State and output registers; reset discards any partial packet
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= ID_BITS'(NUM_STREAMS - 1);
            o_valid_q    <= 1'b0;
            o_last_q     <= 1'b0;
            o_data_q     <= '0;
            o_user_q     <= '0;
            o_id_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            o_valid_q    <= o_valid_d;
            o_last_q     <= o_last_d;
            o_data_q     <= o_data_d;
            o_user_q     <= o_user_d;
            o_id_q       <= o_id_d;
        end
    end

    assign axis_o_tvalid = o_valid_q;
    assign axis_o_tlast  = o_last_q;
    assign axis_o_tdata  = o_data_q;
    assign axis_o_tuser  = o_user_q;
    assign axis_o_tid    = o_id_q;

endmodule

// File: tb/tb_axis_arb_mux.sv
// Directed bench for axis_arb_mux with three streams, one-byte data and one-bit user.
module tb_axis_arb_mux;

    localparam int N   = 3;
    localparam int IDB = 2;

    logic           clk = 1'b0;
    logic           areset;
    logic [N-1:0]   i_tready, i_tvalid, i_tlast, i_tuser;
    logic [N*8-1:0] i_tdata;
    logic           o_tready, o_tvalid, o_tlast, o_tuser;
    logic [7:0]     o_tdata;
    logic [IDB-1:0] o_tid;

    always #5 clk = ~clk;

    axis_arb_mux #(
        .AXIS_BYTES(1), .AXIS_USER_BITS(1), .NUM_STREAMS(N), .ID_BITS(IDB)
    ) dut (
        .clk(clk), .areset(areset),
        .axis_i_tready(i_tready), .axis_i_tvalid(i_tvalid), .axis_i_tlast(i_tlast),
        .axis_i_tdata(i_tdata), .axis_i_tuser(i_tuser),
        .axis_o_tready(o_tready), .axis_o_tvalid(o_tvalid), .axis_o_tlast(o_tlast),
        .axis_o_tdata(o_tdata), .axis_o_tuser(o_tuser), .axis_o_tid(o_tid)
    );

    int errors = 0;
    int checks = 0;

    // source model: per-stream beat list, pointer advanced on handshake
    logic [7:0] src_data [N][16];
    logic       src_last [N][16];
    int         src_len  [N];
    int         src_ptr  [N];
    int         gap_lo   [N];
    int         gap_hi   [N];
    logic [15:0] rdy_pat;
    int          cyc;

    logic [11:0] cap[$];
    int          cap_cyc[$];
    int          viol;
    logic        tr0_seen;
    logic        stall_prev;
    logic [11:0] held;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // packed beat: {tid, user, last, data}; user is data[0]
    function automatic logic [11:0] mk(input int tid, input logic [7:0] d, input logic last);
        return {2'(tid), d[0], last, d};
    endfunction

    task automatic load(input int s, input int base, input int n, input bit all_last);
        for (int k = 0; k < n; k++) begin
            src_data[s][k] = 8'(base + k);
            src_last[s][k] = all_last || (k == n - 1);
        end
        src_len[s] = n;
        src_ptr[s] = 0;
    endtask

    task automatic drive();
        for (int s = 0; s < N; s++) begin
            int  p;
            bit  v;
            p = (src_ptr[s] < src_len[s]) ? src_ptr[s] : 0;
            v = (src_ptr[s] < src_len[s]) && !(cyc >= gap_lo[s] && cyc <= gap_hi[s]);
            i_tvalid[s]       = v;
            i_tlast[s]        = v && src_last[s][p];
            i_tdata[s*8 +: 8] = v ? src_data[s][p] : 8'h00;
            i_tuser[s]        = v && src_data[s][p][0];
        end
        o_tready = rdy_pat[cyc % 16];
    endtask

    task automatic cycle();
        logic [N-1:0] acc;
        logic [11:0]  cur;
        @(negedge clk);
        drive();
        #1;
        cur = {o_tid, o_tuser, o_tlast, o_tdata};
        if (stall_prev && (!o_tvalid || cur != held)) viol++;
        if (o_tvalid && !o_tready && i_tready != '0) viol++;
        if (o_tvalid && o_tready && !o_tlast && i_tready == '0) viol++;
        if ($countones(i_tready) > 1) viol++;
        if (i_tready[0]) tr0_seen = 1'b1;
        stall_prev = o_tvalid && !o_tready;
        held = cur;
        if (o_tvalid && o_tready) begin
            cap.push_back(cur);
            cap_cyc.push_back(cyc);
        end
        acc = i_tvalid & i_tready;
        @(posedge clk);
        for (int s = 0; s < N; s++) if (acc[s]) src_ptr[s]++;
        cyc++;
    endtask

    task automatic clear_tb();
        for (int s = 0; s < N; s++) begin
            src_len[s] = 0;
            src_ptr[s] = 0;
            gap_lo[s]  = 1000;
            gap_hi[s]  = -1;
        end
        rdy_pat    = 16'hFFFF;
        cap.delete();
        cap_cyc.delete();
        viol       = 0;
        tr0_seen   = 1'b0;
        stall_prev = 1'b0;
        held       = '0;
        cyc        = 0;
    endtask

    task automatic reset_dut();
        areset = 1'b1;
        clear_tb();
        drive();
        repeat (2) @(posedge clk);
        #2 areset = 1'b0;
    endtask

    function automatic logic [11:0] cap_at(input int k);
        return (k < cap.size()) ? cap[k] : 12'hFFF;
    endfunction

    function automatic int cyc_at(input int k);
        return (k < cap_cyc.size()) ? cap_cyc[k] : -1;
    endfunction

    initial begin
        i_tvalid = '0; i_tlast = '0; i_tdata = '0; i_tuser = '0; o_tready = 1'b1;
        clear_tb();

        // reset values
        areset = 1'b1;
        drive();
        @(posedge clk);
        #2;
        chk("rst_out", {31'd0, o_tvalid} | {27'd0, o_tlast, o_tuser, o_tid, 1'b0} | {24'd0, o_tdata}, 0);
        chk("rst_ready", 32'(i_tready), 0);

        // two competing 4-beat packets from reset
        reset_dut();
        load(0, 8'h10, 4, 0);
        load(1, 8'h20, 4, 0);
        repeat (16) cycle();
        chk("t1_count", cap.size(), 8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t1_beat%0d", k), cap_at(k),
                (k < 4) ? mk(0, 8'(8'h10 + k), k == 3) : mk(1, 8'(8'h20 + k - 4), k == 7));
            chk($sformatf("t1_cyc%0d", k), cyc_at(k), (k < 4) ? 2 + k : 3 + k);
        end
        chk("t1_viol", viol, 0);

        // single stream 1, 3 beats
        reset_dut();
        load(1, 8'h30, 3, 0);
        repeat (10) cycle();
        chk("t2_count", cap.size(), 3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t2_beat%0d", k), cap_at(k), mk(1, 8'(8'h30 + k), k == 2));
            chk($sformatf("t2_cyc%0d", k), cyc_at(k), 2 + k);
        end
        chk("t2_tready0", 32'(tr0_seen), 0);
        chk("t2_viol", viol, 0);

        // round-robin fairness, 1-beat packets on all streams
        reset_dut();
        for (int s = 0; s < N; s++) load(s, 8'h40 + 8'h10 * s, 3, 1);
        repeat (22) cycle();
        chk("t3_count", cap.size(), 9);
        for (int j = 0; j < 9; j++) begin
            chk($sformatf("t3_beat%0d", j), cap_at(j), mk(j % 3, 8'(8'h40 + 8'h10 * (j % 3) + j / 3), 1'b1));
            chk($sformatf("t3_cyc%0d", j), cyc_at(j), 2 + 2 * j);
        end

        // sink backpressure on a 6-beat packet
        reset_dut();
        load(0, 8'h70, 6, 0);
        rdy_pat = 16'b1110_1101_0100_1101;
        repeat (30) cycle();
        chk("t4_count", cap.size(), 6);
        for (int k = 0; k < 6; k++)
            chk($sformatf("t4_beat%0d", k), cap_at(k), mk(0, 8'(8'h70 + k), k == 5));
        chk("t4_viol", viol, 0);

        // source gap on stream 0 while stream 1 waits
        reset_dut();
        load(0, 8'h80, 5, 0);
        load(1, 8'h90, 2, 0);
        gap_lo[0] = 3;
        gap_hi[0] = 5;
        repeat (20) cycle();
        chk("t5_count", cap.size(), 7);
        for (int k = 0; k < 7; k++)
            chk($sformatf("t5_beat%0d", k), cap_at(k),
                (k < 5) ? mk(0, 8'(8'h80 + k), k == 4) : mk(1, 8'(8'h90 + k - 5), k == 6));
        chk("t5_last0_cyc", cyc_at(4), 9);
        chk("t5_viol", viol, 0);

        // reset during beat 2 of 5
        reset_dut();
        load(0, 8'hA0, 5, 0);
        repeat (4) cycle();
        #1;
        chk("t6_pre_data", {24'd0, o_tdata}, 32'hA2);
        chk("t6_pre_count", cap.size(), 2);
        areset = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(o_tvalid), 0);
        chk("t6_rst_fields", {20'd0, o_tid, o_tuser, o_tlast, o_tdata}, 0);
        chk("t6_rst_ready", 32'(i_tready), 0);
        @(posedge clk);
        clear_tb();
        #2 areset = 1'b0;
        load(0, 8'hB0, 3, 0);
        repeat (10) cycle();
        chk("t6_count", cap.size(), 3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t6_beat%0d", k), cap_at(k), mk(0, 8'(8'hB0 + k), k == 2));
            chk($sformatf("t6_cyc%0d", k), cyc_at(k), 2 + k);
        end
        chk("t6_viol", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
